// File: rtl/jk_bank_driver.sv
// jk_bank_driver: loads an arbitrary target pattern into a bank of external
// JK flip-flops. It computes per-bit J/K excitation from the bank's present Q,
// drives the bank for one clock, reads Q back and retries on mismatch.
module jk_bank_driver #(
  parameter int   WIDTH     = 4,
  parameter logic DC_VAL    = 1'b0,
  parameter int   MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    HOLD  = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] j_r, j_s;
  logic [WIDTH-1:0] k_r, k_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [2:0]       retry_r, retry_s;
  logic [WIDTH-1:0] target_r, target_s;

  // JK excitation: a Q=0 bit only needs J (K is don't-care), a Q=1 bit only
  // needs K (J is don't-care). Result is packed as {J, K}.
  function automatic logic [2*WIDTH-1:0] jk_excite(input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] dc;
    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;
    dc = {WIDTH{DC_VAL}};
    jv = (~q & t)  | (q & dc);
    kv = (q & ~t)  | (~q & dc);
    return {jv, kv};
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: excitation drive, status pulses, readback, retry, target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_r      <= '0;
      k_r      <= '0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      result_r <= '0;
      retry_r  <= 3'd0;
      target_r <= '0;
    end else begin
      j_r      <= j_s;
      k_r      <= k_s;
      done_r   <= done_s;
      err_r    <= err_s;
      result_r <= result_s;
      retry_r  <= retry_s;
      target_r <= target_s;
    end
  end

  // Next-state and next-register decode; excitation is only ever loaded on
  // leaving APPLY, so the bank sees nonzero J/K solely during HOLD.
  always_comb begin
    state_s  = state_r;
    j_s      = '0;
    k_s      = '0;
    done_s   = 1'b0;
    err_s    = 1'b0;
    result_s = result_r;
    retry_s  = retry_r;
    target_s = target_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          target_s = req_target;
          retry_s  = 3'd0;
          state_s  = APPLY;
        end else begin
          state_s  = IDLE;
        end
      end
      APPLY: begin
        {j_s, k_s} = jk_excite(q_in, target_r);
        state_s    = HOLD;
      end
      HOLD: begin
        state_s = CHECK;
      end
      CHECK: begin
        result_s = q_in;
        if (q_in == target_r) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (retry_r < MAX_RETRY_C) begin
          retry_s = retry_r + 3'd1;
          state_s = APPLY;
        end else begin
          err_s   = 1'b1;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign j_out     = j_r;
  assign k_out     = k_r;
  assign done      = done_r;
  assign err       = err_r;
  assign result_q  = result_r;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (DC_VAL=0 and DC_VAL=1), each
// driving a behavioural JK bank with an optional stuck-at-0 mask. Expected
// outcomes are queued at stimulus time and checked by a negedge monitor.
module tb_jk_bank_driver;

  localparam int W  = 4;
  localparam int MR = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld   [2];
  logic [W-1:0] tgt   [2];
  logic [W-1:0] bank  [2];
  logic [W-1:0] stuck [2];
  logic         rdy   [2];
  logic         bsy   [2];
  logic         dn    [2];
  logic         er    [2];
  logic [W-1:0] jo    [2];
  logic [W-1:0] ko    [2];
  logic [W-1:0] res   [2];

  typedef struct {
    int           lane;
    bit           is_err;
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(W), .DC_VAL(1'b0), .MAX_RETRY(MR)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_target(tgt[0]), .q_in(bank[0]), .j_out(jo[0]), .k_out(ko[0]),
    .busy(bsy[0]), .done(dn[0]), .err(er[0]), .result_q(res[0]));

  jk_bank_driver #(.WIDTH(W), .DC_VAL(1'b1), .MAX_RETRY(MR)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_target(tgt[1]), .q_in(bank[1]), .j_out(jo[1]), .k_out(ko[1]),
    .busy(bsy[1]), .done(dn[1]), .err(er[1]), .result_q(res[1]));

  // External JK bank behaviour, with stuck bits forced low
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++)
      bank[l] <= ((jo[l] & ~bank[l]) | (~ko[l] & bank[l])) & ~stuck[l];
  end

  // Rising-edge counter for latency measurement
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int lane, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s lane=%0d got=%0h want=%0h t=%0t", name, lane, got, want, $time);
    end
  endtask

  // Excitation table: (q,t) 0->0 J0 Kdc, 0->1 J1 Kdc, 1->0 Jdc K1, 1->1 Jdc K0
  function automatic logic [2*W-1:0] excite(input logic [W-1:0] q,
                                            input logic [W-1:0] t, input logic dc);
    logic [W-1:0] jj;
    logic [W-1:0] kk;
    for (int i = 0; i < W; i++) begin
      case ({q[i], t[i]})
        2'b00:   begin jj[i] = 1'b0; kk[i] = dc;   end
        2'b01:   begin jj[i] = 1'b1; kk[i] = dc;   end
        2'b10:   begin jj[i] = dc;   kk[i] = 1'b1; end
        2'b11:   begin jj[i] = dc;   kk[i] = 1'b0; end
        default: begin jj[i] = 1'bx; kk[i] = 1'bx; end
      endcase
    end
    return {jj, kk};
  endfunction

  // Monitor: J/K drive every cycle, and done/err pulses against the scoreboard
  int           acc_edge [2];
  bit           active   [2];
  logic [W-1:0] tgt_cap  [2];
  logic [W-1:0] q_prev   [2];

  initial begin
    active   = '{1'b0, 1'b0};
    acc_edge = '{0, 0};
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        int           off;
        logic [2*W-1:0] ejk;
        exp_t         ex;
        if (!rst_n) begin
          active[l] = 1'b0;
        end else begin
          off = edge_cnt - acc_edge[l];
          if (active[l] && (off % 3 == 1))
            ejk = excite(q_prev[l], tgt_cap[l], (l == 1));
          else
            ejk = '0;
          chk("jk_drive", l, 32'({jo[l], ko[l]}), 32'(ejk));
          if (dn[l] || er[l]) begin
            chk("done_err_exclusive", l, 32'(dn[l] & er[l]), 32'd0);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_pulse lane=%0d done=%0b err=%0b", l, dn[l], er[l]);
            end else begin
              ex = exp_q.pop_front();
              chk("resp_lane", l, 32'(l), 32'(ex.lane));
              chk("resp_is_err", l, 32'(er[l]), 32'(ex.is_err));
              chk("resp_result_q", l, 32'(res[l]), 32'(ex.res));
              chk("resp_latency", l, 32'(edge_cnt - acc_edge[l]), 32'(ex.lat));
            end
            active[l] = 1'b0;
          end
          if (vld[l] && rdy[l]) begin
            acc_edge[l] = edge_cnt + 1;
            tgt_cap[l]  = tgt[l];
            active[l]   = 1'b1;
          end
        end
        q_prev[l] = bank[l];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int l, input bit is_err, input logic [W-1:0] r, input int lat);
    exp_t ex;
    ex.lane = l; ex.is_err = is_err; ex.res = r; ex.lat = lat;
    exp_q.push_back(ex);
  endtask

  // Reference outcome: a round lands the bank on the target except for
  // stuck bits; a stuck bit the target needs high exhausts all retries.
  task automatic predict(input int l, input logic [W-1:0] t);
    if ((t & stuck[l]) == '0) push(l, 1'b0, t, 3);
    else                      push(l, 1'b1, t & ~stuck[l], 3 * (MR + 1));
  endtask

  task automatic send(input int l, input logic [W-1:0] t, input bit keep_valid);
    int n;
    n = 0;
    vld[l] = 1'b1;
    tgt[l] = t;
    while (!rdy[l] && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout lane=%0d ready=%0b required=1", l, rdy[l]);
    end
    tick();
    if (!keep_valid) vld[l] = 1'b0;
  endtask

  task automatic wait_idle(input int l);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bsy[l] || dn[l] || er[l]) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout lane=%0d pending=%0d required=0", l, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] saved;
    logic [W-1:0] t;
    int           l;
    vld   = '{1'b0, 1'b0};
    tgt   = '{4'd0, 4'd0};
    stuck = '{4'hF, 4'hF};
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_j", i, 32'(jo[i]), 32'd0);
      chk("rst_k", i, 32'(ko[i]), 32'd0);
      chk("rst_done", i, 32'(dn[i]), 32'd0);
      chk("rst_err", i, 32'(er[i]), 32'd0);
      chk("rst_result", i, 32'(res[i]), 32'd0);
      chk("rst_ready", i, 32'(rdy[i]), 32'd1);
      chk("rst_busy", i, 32'(bsy[i]), 32'd0);
    end
    tick();
    tick();
    stuck = '{4'h0, 4'h0};
    rst_n = 1'b1;
    tick();

    // Bank 0000 -> 1010 with DC_VAL=0
    predict(0, 4'b0000); send(0, 4'b0000, 1'b0); wait_idle(0);
    predict(0, 4'b1010); send(0, 4'b1010, 1'b0); wait_idle(0);
    chk("t1_bank", 0, 32'(bank[0]), 32'(4'b1010));

    // Bank 1100 -> 0110 with DC_VAL=1
    predict(1, 4'b1100); send(1, 4'b1100, 1'b0); wait_idle(1);
    predict(1, 4'b0110); send(1, 4'b0110, 1'b0); wait_idle(1);
    chk("t2_bank", 1, 32'(bank[1]), 32'(4'b0110));

    // Bit 0 stuck low: all retries fail
    stuck[0] = 4'b0001;
    tick();
    predict(0, 4'b0001); send(0, 4'b0001, 1'b0); wait_idle(0);
    stuck[0] = 4'b0000;

    // Bit 0 stuck low, released during the second HOLD: one retry
    stuck[0] = 4'b0001;
    tick();
    push(0, 1'b0, 4'b0001, 6);
    send(0, 4'b0001, 1'b0);
    repeat (4) tick();
    stuck[0] = 4'b0000;
    wait_idle(0);

    // Reset during HOLD aborts without a pulse
    saved = bank[0];
    send(0, ~saved, 1'b0);
    tick();
    chk("t5_hold_jk_nonzero", 0, 32'(({jo[0], ko[0]} != '0)), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_j", 0, 32'(jo[0]), 32'd0);
    chk("t5_rst_k", 0, 32'(ko[0]), 32'd0);
    chk("t5_rst_ready", 0, 32'(rdy[0]), 32'd1);
    chk("t5_rst_busy", 0, 32'(bsy[0]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_bank_held", 0, 32'(bank[0]), 32'(saved));
    predict(0, 4'b0101); send(0, 4'b0101, 1'b0); wait_idle(0);

    // Back-to-back with valid held; target change while busy is ignored
    predict(0, 4'b0011);
    predict(0, 4'b1111);
    send(0, 4'b0011, 1'b1);
    tgt[0] = 4'b1111;
    send(0, 4'b1111, 1'b0);
    wait_idle(0);
    chk("t6_bank", 0, 32'(bank[0]), 32'(4'b1111));

    // Randomized targets and stuck masks on both lanes
    for (int it = 0; it < 24; it++) begin
      l = it % 2;
      stuck[l] = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      tick();
      t = 4'($urandom);
      predict(l, t);
      send(l, t, 1'b0);
      wait_idle(l);
      stuck[l] = 4'b0000;
    end

    chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
